// File: rtl/arm_mux_pkg.sv
// Shared types, defaults and round-robin pick helper for the arbitrated N:1 mux.
package arm_mux_pkg;

   localparam int unsigned DEFAULT_BUS_WIDTH  = 32;
   localparam int unsigned DEFAULT_NUM_INPUTS = 4;
   localparam int unsigned MAX_INPUTS         = 64;
   localparam int unsigned PTR_W              = $clog2(MAX_INPUTS);
   localparam int unsigned IDX_W              = PTR_W + 1;

   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First valid channel searching upward from last_grant+1, wrapping at num_inputs.
   function automatic pick_t rr_pick(input logic [MAX_INPUTS-1:0] valid,
                                     input int unsigned           last_grant,
                                     input int unsigned           num_inputs);
      pick_t       res;
      int unsigned cand;
      res = '0;
      for (int unsigned i = 1; i <= MAX_INPUTS; i++) begin
         cand = last_grant + i;
         if (cand >= num_inputs) cand = cand - num_inputs;
         if (!res.found && (i <= num_inputs) && valid[PTR_W'(cand)]) begin
            res.found = 1'b1;
            res.idx   = IDX_W'(cand);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/arm_arb_mux_nx1_if.sv
// Producer/consumer handshake bundle for arm_arb_mux_nx1.
// i_Last is present only when ARM_ARB_MUX_LOCK_EN is defined.
interface arm_arb_mux_nx1_if #(
   parameter int unsigned BusWidth  = arm_mux_pkg::DEFAULT_BUS_WIDTH,
   parameter int unsigned NumInputs = arm_mux_pkg::DEFAULT_NUM_INPUTS,
   parameter int unsigned SelWidth  = $clog2(NumInputs)
);
   logic [NumInputs-1:0]          i_Valid;
   logic [NumInputs*BusWidth-1:0] i_Data;
`ifdef ARM_ARB_MUX_LOCK_EN
   logic [NumInputs-1:0]          i_Last;
`endif
   logic [NumInputs-1:0]          o_Ready;
   logic                          i_Flush;
   logic                          o_Valid;
   logic [BusWidth-1:0]           o_Data;
   logic [SelWidth-1:0]           o_Source;
   logic                          i_Ready;

`ifdef ARM_ARB_MUX_LOCK_EN
   modport slave  (input  i_Valid, i_Data, i_Last, i_Flush, i_Ready,
                   output o_Ready, o_Valid, o_Data, o_Source);
   modport master (output i_Valid, i_Data, i_Last, i_Flush, i_Ready,
                   input  o_Ready, o_Valid, o_Data, o_Source);
`else
   modport slave  (input  i_Valid, i_Data, i_Flush, i_Ready,
                   output o_Ready, o_Valid, o_Data, o_Source);
   modport master (output i_Valid, i_Data, i_Flush, i_Ready,
                   input  o_Ready, o_Valid, o_Data, o_Source);
`endif
endinterface

// File: rtl/arm_rr_arbiter.sv
// Combinational winner selection: rotating priority or fixed (channel 0 highest).
module arm_rr_arbiter
   import arm_mux_pkg::*;
#(
   parameter int unsigned NumInputs  = DEFAULT_NUM_INPUTS,
   parameter int unsigned SelWidth   = $clog2(NumInputs),
   parameter bit          RoundRobin = 1'b1
) (
   input  logic [NumInputs-1:0] valid,
   input  logic [SelWidth-1:0]  last_grant,
   output logic [SelWidth-1:0]  grant_idx_c,
   output logic                 grant_found_c
);
   localparam int unsigned FP_START = NumInputs - 1;

   int unsigned start;
   pick_t       pick;

   // Fixed priority is a rotating search that always starts after the top channel.
   always_comb begin
      start = RoundRobin ? 32'(last_grant) : FP_START;
      pick  = rr_pick(MAX_INPUTS'(valid), start, NumInputs);
   end

   assign grant_found_c = pick.found && (pick.idx < IDX_W'(NumInputs));
   assign grant_idx_c   = SelWidth'(pick.idx);

endmodule

// File: rtl/arm_arb_mux_nx1.sv
// Arbitrated N:1 mux with one registered output beat and valid/ready on every channel.
// Define ARM_ARB_MUX_LOCK_EN to hold the grant on a channel until its i_Last beat.
module arm_arb_mux_nx1
   import arm_mux_pkg::*;
#(
   parameter int unsigned BusWidth   = DEFAULT_BUS_WIDTH,
   parameter int unsigned NumInputs  = DEFAULT_NUM_INPUTS,
   parameter int unsigned SelWidth   = $clog2(NumInputs),
   parameter bit          RoundRobin = 1'b1
) (
   input logic               i_CLK,
   input logic               i_RESET,
   arm_arb_mux_nx1_if.slave  bus
);
   logic [BusWidth-1:0]  out_data_q;
   logic [SelWidth-1:0]  out_src_q;
   logic                 out_valid_q;
   logic [SelWidth-1:0]  last_grant_q;
   logic [NumInputs-1:0] elig_valid;
   logic [SelWidth-1:0]  grant_idx_c;
   logic                 grant_found_c;
   logic                 load;
   logic                 xfer;
   logic [BusWidth-1:0]  sel_data;

`ifdef ARM_ARB_MUX_LOCK_EN
   lock_state_e          lock_state_q;
   logic [SelWidth-1:0]  lock_idx_q;

   // While locked only the owning channel may compete, even if it is idle.
   always_comb begin
      elig_valid = bus.i_Valid;
      if (lock_state_q == LOCKED) elig_valid = bus.i_Valid & (NumInputs'(1) << lock_idx_q);
   end
`else
   assign elig_valid = bus.i_Valid;
`endif

   arm_rr_arbiter #(
      .NumInputs  (NumInputs),
      .SelWidth   (SelWidth),
      .RoundRobin (RoundRobin)
   ) u_arb (
      .valid         (elig_valid),
      .last_grant    (last_grant_q),
      .grant_idx_c   (grant_idx_c),
      .grant_found_c (grant_found_c)
   );

   assign load     = !bus.i_Flush && (!out_valid_q || bus.i_Ready);
   assign xfer     = load && grant_found_c && !i_RESET;
   assign sel_data = bus.i_Data[32'(grant_idx_c) * BusWidth +: BusWidth];

   assign bus.o_Ready  = xfer ? (NumInputs'(1) << grant_idx_c) : '0;
   assign bus.o_Valid  = out_valid_q;
   assign bus.o_Data   = out_data_q;
   assign bus.o_Source = out_src_q;

   // Output stage, round-robin pointer and lock FSM.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= '0;
         last_grant_q <= SelWidth'(NumInputs - 1);
`ifdef ARM_ARB_MUX_LOCK_EN
         lock_state_q <= UNLOCKED;
         lock_idx_q   <= '0;
`endif
      end else begin
         if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= grant_idx_c;
`ifdef ARM_ARB_MUX_LOCK_EN
            if (bus.i_Last[grant_idx_c]) begin
               lock_state_q <= UNLOCKED;
               last_grant_q <= grant_idx_c;
            end else begin
               lock_state_q <= LOCKED;
               lock_idx_q   <= grant_idx_c;
            end
`else
            last_grant_q <= grant_idx_c;
`endif
         end else if (bus.i_Flush) begin
            out_valid_q <= 1'b0;
`ifdef ARM_ARB_MUX_LOCK_EN
            lock_state_q <= UNLOCKED;
`endif
         end else if (bus.i_Ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arm_arb_mux_nx1.sv
// Directed table-driven bench for arm_arb_mux_nx1: round-robin, fixed-priority and 3-input builds.
module tb_arm_arb_mux_nx1;

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        rdy;
      logic        flush;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [1:0]  exp_src;
      logic [31:0] exp_data;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   valid;
   logic [3:0]   last;
   logic [127:0] data;
   logic [2:0]   valid3;
   logic [95:0]  data3;
   logic         rdy;
   logic         flush;

   int n_cmp = 0;
   int n_err = 0;

   vec_t tbl  [21];
   vec_t ltbl [6];

   always #5 clk = ~clk;

   arm_arb_mux_nx1_if #(.BusWidth(32), .NumInputs(4)) if_rr ();
   arm_arb_mux_nx1_if #(.BusWidth(32), .NumInputs(4)) if_fp ();
   arm_arb_mux_nx1_if #(.BusWidth(32), .NumInputs(3)) if_n3 ();

   assign if_rr.i_Valid = valid;
   assign if_rr.i_Data  = data;
   assign if_rr.i_Flush = flush;
   assign if_rr.i_Ready = rdy;
   assign if_fp.i_Valid = valid;
   assign if_fp.i_Data  = data;
   assign if_fp.i_Flush = flush;
   assign if_fp.i_Ready = rdy;
   assign if_n3.i_Valid = valid3;
   assign if_n3.i_Data  = data3;
   assign if_n3.i_Flush = flush;
   assign if_n3.i_Ready = rdy;
`ifdef ARM_ARB_MUX_LOCK_EN
   assign if_rr.i_Last = last;
   assign if_fp.i_Last = last;
   assign if_n3.i_Last = 3'b111;
`endif

   arm_arb_mux_nx1 #(.BusWidth(32), .NumInputs(4), .RoundRobin(1'b1)) u_rr (
      .i_CLK(clk), .i_RESET(rst), .bus(if_rr));
   arm_arb_mux_nx1 #(.BusWidth(32), .NumInputs(4), .RoundRobin(1'b0)) u_fp (
      .i_CLK(clk), .i_RESET(rst), .bus(if_fp));
   arm_arb_mux_nx1 #(.BusWidth(32), .NumInputs(3), .RoundRobin(1'b1)) u_n3 (
      .i_CLK(clk), .i_RESET(rst), .bus(if_n3));

   function automatic logic [31:0] dat(input int tag, input int ch);
      return 32'hA5A5_0000 | 32'((tag & 8'hFF) << 8) | 32'(ch);
   endfunction

   task automatic set_data(input int tag);
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = dat(tag, k);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Entered at posedge+1: drive, check o_Ready mid-cycle, then registered outputs after the edge.
   task automatic run_vec(input vec_t t, input int idx, input int tag);
      valid = t.valid; last = t.last; rdy = t.rdy; flush = t.flush;
      set_data(tag);
      #4;
      chk("o_Ready", idx, 32'(if_rr.o_Ready), 32'(t.exp_rdy));
      @(posedge clk); #1;
      chk("o_Valid", idx, 32'(if_rr.o_Valid), 32'(t.exp_ov));
      chk("o_Source", idx, 32'(if_rr.o_Source), 32'(t.exp_src));
      chk("o_Data", idx, if_rr.o_Data, t.exp_data);
   endtask

   initial begin
      //           valid    last     rdy   flush exp_rdy  ov    src   data
      tbl[0]  = '{4'b0001, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0000};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA5A5_0101};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0202};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA5A5_0303};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0400};
      tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA5A5_0501};
      tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0602};
      tbl[7]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA5A5_0703};
      tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0800};
      tbl[9]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA5A5_0800};
      tbl[10] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA5A5_0800};
      tbl[11] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA5A5_0800};
      tbl[12] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA5A5_0C01};
      tbl[13] = '{4'b0010, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA5A5_0C01};
      tbl[14] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0E02};
      tbl[15] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA5A5_0E02};
      tbl[16] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA5A5_0E02};
      tbl[17] = '{4'b1001, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA5A5_1103};
      tbl[18] = '{4'b1001, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA5A5_1103};
      tbl[19] = '{4'b1001, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_1300};
      tbl[20] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'hA5A5_1300};

      // Lock sequence: ch1 moves the pointer, then ch2 sends a 3-beat burst.
      ltbl[0] = '{4'b0010, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA5A5_4001};
      ltbl[1] = '{4'b0110, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5A5_4102};
      ltbl[2] = '{4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA5A5_4102};
      ltbl[3] = '{4'b0110, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5A5_4302};
      ltbl[4] = '{4'b0110, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5A5_4402};
      ltbl[5] = '{4'b0110, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA5A5_4501};

      rst = 1'b1; valid = 4'b1111; last = 4'b1111; rdy = 1'b1; flush = 1'b0;
      valid3 = 3'b000;
      set_data(0);
      for (int k = 0; k < 3; k++) data3[k*32 +: 32] = 32'h3000_0000 + 32'(k);

      // Reset state, with requests pending.
      #1;
      chk("rst_o_Valid", 0, 32'(if_rr.o_Valid), 32'd0);
      chk("rst_o_Data", 0, if_rr.o_Data, 32'd0);
      chk("rst_o_Source", 0, 32'(if_rr.o_Source), 32'd0);
      chk("rst_o_Ready", 0, 32'(if_rr.o_Ready), 32'd0);
      chk("rst_fp_o_Ready", 0, 32'(if_fp.o_Ready), 32'd0);
      @(posedge clk); #1;
      chk("rst_o_Valid", 1, 32'(if_rr.o_Valid), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) run_vec(tbl[i], i, i);

      // Load a beat, then reset asynchronously mid-cycle: the beat is lost.
      valid = 4'b1111; rdy = 1'b0; set_data(8'h20);
      @(posedge clk); #1;
      chk("pre_rst_o_Valid", 0, 32'(if_rr.o_Valid), 32'd1);
      chk("pre_rst_o_Source", 0, 32'(if_rr.o_Source), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_o_Valid", 0, 32'(if_rr.o_Valid), 32'd0);
      chk("mid_rst_o_Data", 0, if_rr.o_Data, 32'd0);
      chk("mid_rst_o_Source", 0, 32'(if_rr.o_Source), 32'd0);
      chk("mid_rst_o_Ready", 0, 32'(if_rr.o_Ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // All channels requesting: round-robin rotates from ch0, fixed priority sticks at ch0.
      for (int i = 0; i < 8; i++) begin
         valid = 4'b1111; rdy = 1'b1; set_data(8'h30 + i);
         #4;
         chk("rr8_o_Ready", i, 32'(if_rr.o_Ready), 32'(4'b0001 << (i % 4)));
         chk("fp8_o_Ready", i, 32'(if_fp.o_Ready), 32'd1);
         @(posedge clk); #1;
         chk("rr8_o_Source", i, 32'(if_rr.o_Source), 32'(i % 4));
         chk("rr8_o_Data", i, if_rr.o_Data, dat(8'h30 + i, i % 4));
         chk("fp8_o_Source", i, 32'(if_fp.o_Source), 32'd0);
         chk("fp8_o_Data", i, if_fp.o_Data, dat(8'h30 + i, 0));
      end
      valid = 4'b0000;
      @(posedge clk); #1;
      chk("drain_o_Valid", 0, 32'(if_rr.o_Valid), 32'd0);

      // Three inputs: the pointer must wrap 2 -> 0.
      for (int i = 0; i < 4; i++) begin
         valid3 = 3'b111; rdy = 1'b1;
         #4;
         chk("n3_o_Ready", i, 32'(if_n3.o_Ready), 32'(3'b001 << (i % 3)));
         @(posedge clk); #1;
         chk("n3_o_Source", i, 32'(if_n3.o_Source), 32'(i % 3));
         chk("n3_o_Data", i, if_n3.o_Data, 32'h3000_0000 + 32'(i % 3));
      end
      valid3 = 3'b000;

`ifdef ARM_ARB_MUX_LOCK_EN
      for (int i = 0; i < 6; i++) run_vec(ltbl[i], 100 + i, 8'h40 + i);
`endif

      valid = 4'b0000;
      @(posedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
